// File: rtl/memory_writer_pkg.sv
// Shared types and constants for the button-driven memory entry writer.
package memory_writer_pkg;

  localparam int DATA_W = 16;

  localparam int BTN_NEXT  = 0;
  localparam int BTN_PREV  = 1;
  localparam int BTN_WRITE = 2;
  localparam int BTN_CLEAR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic int addr_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, accepts a level change after DEBOUNCE_CYCLES stable
// samples, and emits a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             level_d_r;
  logic             pulse_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer, debounce counter and rising-edge pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      pulse_r   <= 1'b0;
      cnt_r     <= '0;
    end else begin
      sync1_r   <= btn_raw;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      pulse_r   <= level_r & ~level_d_r;
      if (sync2_r != level_r) begin
        // The toggling edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
        if (cnt_r == CNT_LAST) begin
          level_r <= ~level_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign btn_level = level_r;
  assign btn_pulse = pulse_r;

endmodule

// File: rtl/memory_entry_writer.sv
// Turns debounced next/prev/write/clear buttons into single-cycle memory write
// strobes, keeping the edit index and sweeping the memory to zero on clear.
module memory_entry_writer
  import memory_writer_pkg::*;
#(
  parameter int MEM_SIZE        = 17,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_INC        = 1,
  localparam int ADDR_W         = addr_w(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_write,
  input  logic              btn_clear,
  input  logic [DATA_W-1:0] sw,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] cur_index,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_SIZE - 1);

  logic [3:0] raw_s;
  logic [3:0] pulse_s;
  logic [3:0] levels_unused_s;

  assign raw_s = {btn_clear, btn_write, btn_prev, btn_next};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (raw_s[i]),
      .btn_level(levels_unused_s[i]),
      .btn_pulse(pulse_s[i])
    );
  end

  state_t            state_r,     state_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r,   clr_cnt_nxt_s;
  logic [ADDR_W-1:0] cur_index_r, cur_index_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r,   wr_addr_nxt_s;
  logic [DATA_W-1:0] wr_data_r,   wr_data_nxt_s;
  logic              wr_en_r,     wr_en_nxt_s;
  logic              busy_r,      busy_nxt_s;

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      clr_cnt_r   <= '0;
      cur_index_r <= '0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      wr_en_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      cur_index_r <= cur_index_nxt_s;
      wr_addr_r   <= wr_addr_nxt_s;
      wr_data_r   <= wr_data_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Next-state selection with clear > write priority in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pulse_s[BTN_CLEAR]) begin
          state_nxt_s = CLEAR;
        end else if (pulse_s[BTN_WRITE]) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: state_nxt_s = IDLE;
      CLEAR: begin
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Register next-values; outputs are registered so they line up with state_r.
  always_comb begin
    clr_cnt_nxt_s   = clr_cnt_r;
    cur_index_nxt_s = cur_index_r;
    wr_addr_nxt_s   = wr_addr_r;
    wr_data_nxt_s   = wr_data_r;
    wr_en_nxt_s     = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pulse_s[BTN_CLEAR]) begin
          clr_cnt_nxt_s = '0;
          wr_addr_nxt_s = '0;
          wr_data_nxt_s = '0;
          wr_en_nxt_s   = 1'b1;
          busy_nxt_s    = 1'b1;
        end else if (pulse_s[BTN_WRITE]) begin
          wr_addr_nxt_s = cur_index_r;
          wr_data_nxt_s = sw;
          wr_en_nxt_s   = 1'b1;
        end else if (pulse_s[BTN_NEXT]) begin
          if (cur_index_r < LAST_IDX) begin
            cur_index_nxt_s = cur_index_r + ADDR_W'(1);
          end else begin
            cur_index_nxt_s = cur_index_r;
          end
        end else if (pulse_s[BTN_PREV]) begin
          if (cur_index_r != '0) begin
            cur_index_nxt_s = cur_index_r - ADDR_W'(1);
          end else begin
            cur_index_nxt_s = cur_index_r;
          end
        end else begin
          cur_index_nxt_s = cur_index_r;
        end
      end
      WRITE: begin
        if ((AUTO_INC != 0) && (cur_index_r < LAST_IDX)) begin
          cur_index_nxt_s = cur_index_r + ADDR_W'(1);
        end else begin
          cur_index_nxt_s = cur_index_r;
        end
      end
      CLEAR: begin
        // clr_cnt_r tracks the address being written this cycle.
        if (clr_cnt_r == LAST_IDX) begin
          cur_index_nxt_s = '0;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
          wr_addr_nxt_s = clr_cnt_r + ADDR_W'(1);
          wr_data_nxt_s = '0;
          wr_en_nxt_s   = 1'b1;
          busy_nxt_s    = 1'b1;
        end
      end
      default: begin
        cur_index_nxt_s = cur_index_r;
      end
    endcase
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign cur_index = cur_index_r;
  assign busy      = busy_r;

endmodule
